// File: rtl/rom_loader_pkg.sv
// Shared types and defaults for the runtime ROM image loader (rom_loader and loader_ram).
// The FSM state encoding is defined here so that checkers can decode the debug state output.
package rom_loader_pkg;

    localparam int DEFAULT_ADDR_WIDTH  = 14;
    localparam int DEFAULT_DATA_WIDTH  = 8;
    localparam int DEFAULT_LOAD_LENGTH = 2 ** DEFAULT_ADDR_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } loader_state_t;

    // A load fills the whole memory unless the caller asks for a shorter image.
    function automatic int load_length_for(input int addr_width);
        return 1 << addr_width;
    endfunction

endpackage

// File: rtl/rom_loader_ram.sv
// Simple dual-port block RAM: one synchronous write port and one registered read port.
// The read data register returns zero whenever the read is not enabled.
module loader_ram
    import rom_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    input  logic                  ren,
    output logic [DATA_WIDTH-1:0] q
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Storage has no reset so it maps onto block RAM; contents survive a reset.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            q <= '0;
        end else if (ren) begin
            q <= mem[raddr];
        end else begin
            q <= '0;
        end
    end

endmodule

// File: rtl/rom_loader.sv
// Runtime ROM image loader: streams words into block RAM, then serves registered reads.
// Optional image checksum is compiled in with `define ROM_LOADER_CHECKSUM_EN.
module rom_loader
    import rom_loader_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int LOAD_LENGTH = load_length_for(ADDR_WIDTH)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  busy,
    output logic                  done,
    input  logic [DATA_WIDTH-1:0] expected_sum,
    output logic                  checksum_ok,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic                  enable,
    output logic [DATA_WIDTH-1:0] q,
    output logic [1:0]            state_dbg
);

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_LOAD = LOAD;
    localparam logic [1:0] S_DONE = DONE;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(LOAD_LENGTH - 1);

    // Stream handshake: a word transfers on every rising edge where in_valid and
    // in_ready are both high; in_ready depends only on registered state, never on in_valid.

    logic [1:0]            state;
    logic [1:0]            state_nxt;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic                  beat;
    logic                  last_beat;
    logic                  load_start;
    logic                  read_en;

    assign in_ready   = (state == S_LOAD);
    assign busy       = (state == S_LOAD);
    assign done       = (state == S_DONE);
    assign state_dbg  = state;

    assign beat       = in_valid && in_ready;
    assign last_beat  = beat && (wr_addr == LAST_ADDR);
    assign load_start = start && ((state == S_IDLE) || (state == S_DONE));

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                if (last_beat) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (start) begin
                    state_nxt = S_LOAD;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The address holds on the final beat so it can never wrap past the image.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_addr <= '0;
        end else if (load_start) begin
            wr_addr <= '0;
        end else if (beat && !last_beat) begin
            wr_addr <= wr_addr + 1'b1;
        end
    end

`ifdef ROM_LOADER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] sum;

    always_ff @(posedge clock) begin
        if (reset) begin
            sum <= '0;
        end else if (load_start) begin
            sum <= '0;
        end else if (beat) begin
            sum <= sum + in_data;
        end
    end

    assign checksum_ok = done && (sum == expected_sum);
`else
    logic unused_expected_sum;

    assign unused_expected_sum = ^expected_sum;
    assign checksum_ok         = done;
`endif

    // Reads are only honoured once the image is complete.
    assign read_en = enable && (state == S_DONE);

    loader_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .clock (clock),
        .reset (reset),
        .we    (beat),
        .waddr (wr_addr),
        .wdata (in_data),
        .raddr (address),
        .ren   (read_en),
        .q     (q)
    );

endmodule

// File: tb/tb_rom_loader.sv
// Scoreboard bench for rom_loader with a word-level reference model of the loader.
// Honours `define ROM_LOADER_CHECKSUM_EN when predicting checksum_ok.
module tb_rom_loader;

    localparam int AW  = 4;
    localparam int DW  = 8;
    localparam int LEN = 16;

    // clock / reset block
    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic          busy;
    logic          done;
    logic [DW-1:0] expected_sum;
    logic          checksum_ok;
    logic [AW-1:0] address;
    logic          enable;
    logic [DW-1:0] q;
    logic [1:0]    state_dbg;

    always #5 clock = ~clock;

    rom_loader #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .LOAD_LENGTH (LEN)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .busy         (busy),
        .done         (done),
        .expected_sum (expected_sum),
        .checksum_ok  (checksum_ok),
        .address      (address),
        .enable       (enable),
        .q            (q),
        .state_dbg    (state_dbg)
    );

    // scoreboard state
    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] exp_q[$];
    logic [3:0]    exp_st_q[$];
    logic          rd_tag  = 1'b0;
    logic          rd_pend = 1'b0;

    // reference model: image memory, load progress, running sum
    logic [DW-1:0] m_mem[LEN];
    bit            m_loading = 1'b0;
    bit            m_ready   = 1'b0;
    int            m_count   = 0;
    logic [DW-1:0] m_sum     = '0;
    logic [DW-1:0] img[LEN];

    task automatic cmp(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // monitor: one registered read result and one status snapshot per cycle
    always @(posedge clock) rd_pend <= rd_tag;

    always @(negedge clock) begin
        logic [DW-1:0] e;
        logic [3:0]    s;
        if (rd_pend) begin
            if (exp_q.size() == 0 || exp_st_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_underflow: got empty queue expected entry at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                s = exp_st_q.pop_front();
                cmp("q", q, e);
                cmp("busy", {7'd0, busy}, {7'd0, s[3]});
                cmp("in_ready", {7'd0, in_ready}, {7'd0, s[2]});
                cmp("done", {7'd0, done}, {7'd0, s[1]});
                cmp("checksum_ok", {7'd0, checksum_ok}, {7'd0, s[0]});
            end
        end
    end

    // driver: one clock cycle of stimulus plus the model's prediction for it
    task automatic cycle(input bit rst, input bit st, input bit v, input logic [DW-1:0] d,
                         input bit en, input logic [AW-1:0] a, input logic [DW-1:0] es);
        bit cs;
        reset        = rst;
        start        = st;
        in_valid     = v;
        in_data      = d;
        enable       = en;
        address      = a;
        expected_sum = es;
        rd_tag       = 1'b1;
        exp_q.push_back((!rst && en && m_ready) ? m_mem[a] : '0);
        @(posedge clock);
        if (rst) begin
            m_loading = 1'b0;
            m_ready   = 1'b0;
            m_count   = 0;
            m_sum     = '0;
        end else if (m_loading) begin
            if (v) begin
                m_mem[m_count] = d;
                m_sum          = m_sum + d;
                m_count++;
                if (m_count == LEN) begin
                    m_loading = 1'b0;
                    m_ready   = 1'b1;
                end
            end
        end else if (st) begin
            m_loading = 1'b1;
            m_ready   = 1'b0;
            m_count   = 0;
            m_sum     = '0;
        end
`ifdef ROM_LOADER_CHECKSUM_EN
        cs = m_ready && (m_sum == es);
`else
        cs = m_ready;
`endif
        exp_st_q.push_back({m_loading, m_loading, m_ready, cs});
        @(negedge clock);
    endtask

    task automatic idle(input bit en, input logic [AW-1:0] a);
        cycle(1'b0, 1'b0, 1'b0, DW'($urandom), en, a, DW'($urandom));
    endtask

    // start a load of img[], with optional gaps, stray start pulses and abort-by-reset
    task automatic load_image(input int gap_pct, input bit mid_start, input int abort_after);
        int i;
        bit v;
        cycle(1'b0, 1'b1, 1'b0, '0, 1'($urandom), AW'($urandom), '0);
        i = 0;
        while (i < LEN) begin
            if (abort_after >= 0 && i == abort_after) begin
                cycle(1'b1, 1'b1, 1'b1, DW'($urandom), 1'b1, AW'($urandom), '0);
                return;
            end
            v = ($urandom_range(0, 99) >= gap_pct);
            cycle(1'b0, mid_start && 1'($urandom), v, v ? img[i] : DW'($urandom),
                  1'($urandom), AW'($urandom), DW'($urandom));
            if (v) i++;
        end
    endtask

    task automatic read_all();
        for (int a = 0; a < LEN; a++) idle(1'b1, AW'(a));
        idle(1'b0, AW'($urandom));
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0;
        enable = 1'b0; address = '0; expected_sum = '0;
        @(negedge clock);

        repeat (3) cycle(1'b1, 1'b0, 1'b0, '0, 1'b1, AW'($urandom), '0);
        idle(1'b1, 4'd3);

        for (int i = 0; i < LEN; i++) img[i] = DW'(i);
        load_image(0, 1'b0, -1);
        idle(1'b1, 4'd5);
        idle(1'b0, 4'd5);
        read_all();
        cycle(1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 8'h78);
        cycle(1'b0, 1'b0, 1'b0, '0, 1'b0, '0, 8'h77);

        load_image(40, 1'b0, -1);
        read_all();

        for (int i = 0; i < LEN; i++) img[i] = DW'($urandom);
        load_image(0, 1'b0, 7);
        idle(1'b1, 4'd0);
        for (int i = 0; i < LEN; i++) img[i] = DW'(8'hF0 + i);
        load_image(25, 1'b1, -1);
        idle(1'b1, 4'd0);
        idle(1'b1, 4'd15);
        read_all();

        for (int n = 0; n < 4; n++) begin
            for (int i = 0; i < LEN; i++) img[i] = DW'($urandom);
            load_image($urandom_range(0, 50), 1'b1, -1);
            cycle(1'b0, 1'b0, 1'b0, '0, 1'b1, AW'($urandom), m_sum);
            cycle(1'b0, 1'b0, 1'b0, '0, 1'b1, AW'($urandom), m_sum + 8'd1);
            read_all();
        end

        rd_tag = 1'b0;
        repeat (2) @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rom_loader.md
# rom_loader

Writer-side companion to the cartridge's synchronous ROM blocks. Accepts a byte stream from the boot/flash path over a valid/ready handshake and writes it sequentially into an internal block RAM. Once the image is complete, it serves registered reads through the same address/enable/q interface the ROM blocks use. This lets ROM images be loaded at runtime instead of being fixed at synthesis.

## Interface
- ADDR_WIDTH, 14, read/write address width; memory depth is 2**ADDR_WIDTH
- DATA_WIDTH, 8, word width
- LOAD_LENGTH, 2**ADDR_WIDTH, number of words per load; legal range 1..2**ADDR_WIDTH
- clock  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle request to begin a load
- in_data  in  DATA_WIDTH  stream word
- in_valid  in  1  in_data valid
- in_ready  out  1  loader accepts in_data this cycle
- busy  out  1  load in progress
- done  out  1  image complete; reads valid
- expected_sum  in  DATA_WIDTH  reference checksum; ignored unless the checksum feature is compiled in
- checksum_ok  out  1  image checksum matches
- address  in  ADDR_WIDTH  read address
- enable  in  1  read enable
- q  out  DATA_WIDTH  registered read data

## Operation
- FSM states: IDLE, LOAD, DONE. Reset forces IDLE, clears the write address and the checksum accumulator, and sets q=0, busy=0, done=0, in_ready=0, checksum_ok=0.
- IDLE: start -> LOAD, with the write address cleared to 0.
- LOAD: in_ready=1, busy=1. Each beat with in_valid&&in_ready writes in_data to mem[wr_addr], then increments wr_addr. The beat with wr_addr==LOAD_LENGTH-1 moves the FSM to DONE. start is ignored in LOAD.
- DONE: done=1. start -> LOAD, restarting at address 0 and clearing the accumulator; done drops the next cycle.
- Read port: q <= (enable && state==DONE) ? mem[address] : 0. q is never high-Z.
- Words beyond LOAD_LENGTH keep their prior contents.
- wr_addr never wraps; the LOAD_LENGTH terminal count ends the load first.
- Reset mid-load returns the FSM to IDLE. Memory contents are not cleared.

## Timing
- in_ready and busy are decoded from the registered state only, with no combinational path from in_valid. Throughput is one word per cycle.
- done rises the cycle after the last beat is accepted, and in_ready falls on that same cycle.
- Read latency is 1 cycle: address/enable sampled at edge N, q valid after edge N.
- If a read targets an address on the cycle the FSM enters DONE, it returns 0, because the state was still LOAD when sampled.
- If start and reset are asserted together, reset wins.
- If start arrives on the cycle of the final beat, start is ignored and the FSM goes to DONE.

## Configuration
- ROM_LOADER_CHECKSUM_EN defined:
  - A DATA_WIDTH accumulator (modulo 2**DATA_WIDTH) sums every accepted word.
  - In DONE, checksum_ok = (sum == expected_sum), evaluated combinationally against the registered sum; it is 0 outside DONE.
- ROM_LOADER_CHECKSUM_EN undefined:
  - No accumulator is built.
  - checksum_ok equals done.
  - expected_sum is unused.

## Structure
- Shared package rom_loader_pkg holds:
  - the enum loader_state_t {IDLE, LOAD, DONE}
  - the localparam for default LOAD_LENGTH
- One sub-module, loader_ram: a simple dual-port RAM with one write port (we, waddr, wdata) and a registered read port (raddr, ren, q, zero when ren=0).
- The FSM, address counter and checksum live in rom_loader.

## Test plan
All scenarios use ADDR_WIDTH=4, LOAD_LENGTH=16, DATA_WIDTH=8.
- Reset held 3 cycles -> q=0, done=0, busy=0, in_ready=0, checksum_ok=0.
- start, then 0x00..0x0F streamed back-to-back -> done=1 exactly one cycle after the 16th beat; then address=5, enable=1 -> q=0x05 one cycle later; enable=0 -> q=0x00.
- in_valid toggled 1-0-1 with gaps -> only valid beats are written; mem holds 0x00..0x0F in order; done rises after the 16th accepted beat.
- Reset after 7 beats -> IDLE, busy=0; a new load of 0xF0..0xFF -> address 0 reads 0xF0 and address 15 reads 0xFF. start pulsed mid-load -> no restart.
- Read with enable=1 during LOAD -> q=0. start in DONE -> done falls next cycle and the reload overwrites from address 0.
- With ROM_LOADER_CHECKSUM_EN, load 0x00..0x0F (sum 0x78):
  - expected_sum=0x78 -> checksum_ok=1
  - expected_sum=0x77 -> checksum_ok=0
  - without the macro -> checksum_ok tracks done.
